// File: rtl/bayer_pkg.sv
// bayer_pkg: shared constants, site type and CFA site lookup for the Bayer demosaic block
package bayer_pkg;

   localparam logic MODE_DECIM = 1'b0;
   localparam logic MODE_FULL  = 1'b1;

   // Green is averaged from two samples, so its sum needs one guard bit above DW.
   localparam int GSUM_EXTRA = 1;

   typedef enum logic [1:0] {SITE_R, SITE_G, SITE_B} site_t;

   // parity = {row[0], col[0]}; bayer = parity of the R site, B sits at ~bayer.
   function automatic site_t site_is(input logic [1:0] parity, input logic [1:0] bayer);
      return (parity == bayer) ? SITE_R : (parity == ~bayer) ? SITE_B : SITE_G;
   endfunction

endpackage

// File: rtl/bayer_line_ram.sv
// bayer_line_ram: single-port read-before-write line buffer holding the previous row
//   iCLK  clock
//   iWE   write/read enable (accepted pixel)
//   iADDR column address
//   iDATA pixel to store
//   oQ    pixel previously stored at iADDR, registered
module bayer_line_ram #(
   parameter int DW    = 12,
   parameter int DEPTH = 1280,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          iCLK,
   input  logic          iWE,
   input  logic [AW-1:0] iADDR,
   input  logic [DW-1:0] iDATA,
   output logic [DW-1:0] oQ
);

   logic [DW-1:0] mem [DEPTH];

   always_ff @(posedge iCLK)
      if (iWE) begin
         oQ <= mem[iADDR];
         mem[iADDR] <= iDATA;
      end

endmodule

// File: rtl/bayer_demosaic.sv
// bayer_demosaic: Bayer CFA to RGB, 2x2 decimation or full resolution, 2-cycle latency
//   iCLK/iRST        clock, asynchronous active-low reset
//   iDATA/iDVAL      raw pixel and its valid
//   iX_Cont/iY_Cont  pixel column/row
//   iMODE            0 decimate, 1 full resolution (taken at frame start)
//   oRed/oGreen/oBlue/oDVAL  RGB pixel and single-cycle strobe
//   oMODE            mode in effect
//   oOVF             sticky: a pixel arrived beyond the line buffer
module bayer_demosaic
   import bayer_pkg::*;
#(
   parameter int         DW     = 12,
   parameter int         LINE_W = 1280,
   parameter int         XW     = 11,
   parameter int         YW     = 11,
   parameter logic [1:0] BAYER  = 2'b00
) (
   input  logic          iCLK,
   input  logic          iRST,
   input  logic [DW-1:0] iDATA,
   input  logic          iDVAL,
   input  logic [XW-1:0] iX_Cont,
   input  logic [YW-1:0] iY_Cont,
   input  logic          iMODE,
   output logic [DW-1:0] oRed,
   output logic [DW-1:0] oGreen,
   output logic [DW-1:0] oBlue,
   output logic          oDVAL,
   output logic          oMODE,
   output logic          oOVF
);

   localparam int AW = $clog2(LINE_W);
   localparam int GW = DW + GSUM_EXTRA;

   if (LINE_W < 2) begin : gBadLineW
      $error("bayer_demosaic: LINE_W must be at least 2");
   end

   logic          inRange, accepted, emit, modeReg, v1;
   logic [DW-1:0] cur, curD, upD, up, red, blue;
   logic [XW-1:0] x1;
   logic [YW-1:0] y1;
   logic [GW-1:0] gSum;
   logic [DW-1:0] win [4];

   assign inRange  = 32'(iX_Cont) < LINE_W;
   assign accepted = iDVAL && inRange;
   assign oMODE    = modeReg;

   bayer_line_ram #(.DW(DW), .DEPTH(LINE_W), .AW(AW)) uRam (
      .iCLK  (iCLK),
      .iWE   (accepted),
      .iADDR (iX_Cont[AW-1:0]),
      .iDATA (iDATA),
      .oQ    (up)
   );

   // Index bit 0 = one column back, bit 1 = one row back; that flips the
   // matching parity bit relative to cur at (y1, x1).
   assign win = '{cur, curD, up, upD};

   always_comb begin
      red  = '0;
      blue = '0;
      gSum = '0;
      for (int i = 0; i < 4; i++) begin
         red  = (site_is({y1[0] ^ i[1], x1[0] ^ i[0]}, BAYER) == SITE_R) ? win[i] : red;
         blue = (site_is({y1[0] ^ i[1], x1[0] ^ i[0]}, BAYER) == SITE_B) ? win[i] : blue;
         gSum = (site_is({y1[0] ^ i[1], x1[0] ^ i[0]}, BAYER) == SITE_G) ? gSum + GW'(win[i]) : gSum;
      end
      emit = v1 && ((modeReg == MODE_FULL) ? (x1 != '0 && y1 != '0) : (x1[0] && y1[0]));
   end

   always_ff @(posedge iCLK or negedge iRST)
      if (!iRST) begin
         cur     <= '0;
         curD    <= '0;
         upD     <= '0;
         x1      <= '0;
         y1      <= '0;
         v1      <= 1'b0;
         modeReg <= MODE_DECIM;
         oOVF    <= 1'b0;
         oDVAL   <= 1'b0;
         oRed    <= '0;
         oGreen  <= '0;
         oBlue   <= '0;
      end else begin
         if (accepted) begin
            cur  <= iDATA;
            curD <= cur;
            upD  <= up;
            x1   <= iX_Cont;
            y1   <= iY_Cont;
         end
         v1 <= accepted;
         if (accepted && iX_Cont == '0 && iY_Cont == '0)
            modeReg <= iMODE;
         if (iDVAL && !inRange)
            oOVF <= 1'b1;
         oDVAL <= emit;
         if (emit) begin
            oRed   <= red;
            oGreen <= gSum[GW-1:1];
            oBlue  <= blue;
         end
      end

endmodule

// File: tb/tb_bayer_demosaic.sv
// tb_bayer_demosaic: directed frames against a frame-array model for BAYER=00 and BAYER=11 instances
module tb_bayer_demosaic;

   localparam int LW = 8;

   logic        clk = 0;
   logic        rstn = 0;
   logic [11:0] iDATA = 0;
   logic        iDVAL = 0;
   logic [10:0] iX = 0;
   logic [10:0] iY = 0;
   logic        iMODE = 0;
   logic [11:0] red0, grn0, blu0, red1, grn1, blu1;
   logic        dval0, dval1, mode0, mode1, ovf0, ovf1;

   always #5 clk = ~clk;

   bayer_demosaic #(.DW(12), .LINE_W(LW), .XW(11), .YW(11), .BAYER(2'b00)) dut0 (
      .iCLK(clk), .iRST(rstn), .iDATA(iDATA), .iDVAL(iDVAL), .iX_Cont(iX), .iY_Cont(iY),
      .iMODE(iMODE), .oRed(red0), .oGreen(grn0), .oBlue(blu0), .oDVAL(dval0),
      .oMODE(mode0), .oOVF(ovf0));

   bayer_demosaic #(.DW(12), .LINE_W(LW), .XW(11), .YW(11), .BAYER(2'b11)) dut1 (
      .iCLK(clk), .iRST(rstn), .iDATA(iDATA), .iDVAL(iDVAL), .iX_Cont(iX), .iY_Cont(iY),
      .iMODE(iMODE), .oRed(red1), .oGreen(grn1), .oBlue(blu1), .oDVAL(dval1),
      .oMODE(mode1), .oOVF(ovf1));

   typedef struct {int t; int r0, g0, b0, r1, g1, b1;} exp_t;

   exp_t q[$];
   int   fr [8][8];
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;
   int   outCnt = 0;
   logic mMode = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s: got %0d want %0d (cycle %0d)", n, a, e, cyc);
      end
   endtask

   // Colour of the 2x2 neighbourhood ending at (y, x), straight from the CFA rules.
   function automatic void calc(input int x, input int y, input logic [1:0] bay,
                                output int r, output int g, output int b);
      int gs;
      logic [1:0] p;
      gs = 0; r = 0; b = 0;
      for (int yy = y - 1; yy <= y; yy++)
         for (int xx = x - 1; xx <= x; xx++) begin
            p = {yy[0], xx[0]};
            if (p == bay) r = fr[yy][xx];
            else if (p == ~bay) b = fr[yy][xx];
            else gs += fr[yy][xx];
         end
      g = gs / 2;
   endfunction

   task automatic px(input int x, input int y, input int d, input logic m);
      exp_t e;
      @(posedge clk);
      #1;
      iDATA = 12'(d); iDVAL = 1; iX = 11'(x); iY = 11'(y); iMODE = m;
      if (x < LW) begin
         fr[y][x] = d;
         if (x == 0 && y == 0) mMode = m;
         if (mMode ? (x >= 1 && y >= 1) : (x % 2 == 1 && y % 2 == 1)) begin
            e.t = cyc + 2;
            calc(x, y, 2'b00, e.r0, e.g0, e.b0);
            calc(x, y, 2'b11, e.r1, e.g1, e.b1);
            q.push_back(e);
         end
      end
   endtask

   task automatic idle();
      @(posedge clk);
      #1;
      iDVAL = 0;
   endtask

   task automatic frame(input int w, input int h, input logic m0, input logic m1,
                        input int kind, input logic gap);
      outCnt = 0;
      for (int y = 0; y < h; y++)
         for (int x = 0; x < w; x++) begin
            px(x, y, kind ? 4095 : 16 * y + x, (x == 0 && y == 0) ? m0 : m1);
            if (gap && x % 2 == 0) begin
               idle(); idle();
            end
         end
      repeat (4) idle();
      chk("queue_drained", q.size(), 0);
   endtask

   always @(negedge clk)
      if (rstn) begin
         automatic logic want = q.size() > 0 && q[0].t == cyc;
         exp_t e;
         if (dval0) outCnt++;
         if (want || dval0 || dval1) begin
            chk("dval_b00", dval0, want);
            chk("dval_b11", dval1, want);
            if (want) begin
               e = q.pop_front();
               chk("red_b00", red0, e.r0);
               chk("green_b00", grn0, e.g0);
               chk("blue_b00", blu0, e.b0);
               chk("red_b11", red1, e.r1);
               chk("green_b11", grn1, e.g1);
               chk("blue_b11", blu1, e.b1);
            end
         end
      end

   task automatic chkIdle(input string n);
      chk({n, "_red"}, red0, 0);
      chk({n, "_green"}, grn0, 0);
      chk({n, "_blue"}, blu0, 0);
      chk({n, "_dval"}, dval0, 0);
      chk({n, "_mode"}, mode0, 0);
      chk({n, "_ovf"}, ovf0, 0);
      chk({n, "_ovf_b11"}, ovf1, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int r, g, b;
      repeat (3) @(posedge clk);
      #1;
      chkIdle("reset");
      rstn = 1;

      frame(4, 4, 0, 0, 0, 0);
      chk("decim_count", outCnt, 4);
      chk("decim_mode", mode0, 0);
      calc(1, 1, 2'b00, r, g, b);
      chk("pin_q11_r", r, 0); chk("pin_q11_g", g, 8); chk("pin_q11_b", b, 17);
      calc(1, 1, 2'b11, r, g, b);
      chk("pin_b11_r", r, 17); chk("pin_b11_g", g, 8); chk("pin_b11_b", b, 0);
      calc(2, 2, 2'b00, r, g, b);
      chk("pin_22_r", r, 34); chk("pin_22_g", g, 25); chk("pin_22_b", b, 17);

      frame(4, 4, 1, 1, 0, 0);
      chk("full_count", outCnt, 9);
      chk("full_mode", mode0, 1);

      frame(4, 4, 0, 1, 0, 0);
      chk("toggle_count", outCnt, 4);
      chk("toggle_mode", mode0, 0);
      chk("toggle_mode_b11", mode1, 0);
      frame(4, 4, 1, 1, 0, 0);
      chk("next_frame_count", outCnt, 9);
      chk("next_frame_mode", mode0, 1);

      frame(LW, 2, 1, 1, 1, 0);
      chk("fullscale_count", outCnt, LW - 1);
      chk("fullscale_green", grn0, 4095);
      chk("edge_x_no_ovf", ovf0, 0);

      frame(4, 4, 1, 1, 0, 1);
      chk("gap_count", outCnt, 9);

      outCnt = 0;
      for (int y = 0; y < 4; y++)
         for (int x = 0; x < 4; x++) begin
            px(x, y, 16 * y + x, 0);
            if (y == 1 && x == 1) px(LW, 1, 999, 0);
         end
      repeat (4) idle();
      chk("ovf_count", outCnt, 4);
      chk("ovf_set", ovf0, 1);
      chk("ovf_set_b11", ovf1, 1);
      repeat (3) idle();
      chk("ovf_sticky", ovf0, 1);

      px(0, 0, 5, 1); px(1, 0, 6, 1); px(2, 0, 7, 1); px(3, 0, 8, 1);
      px(0, 1, 9, 1); px(1, 1, 10, 1);
      @(posedge clk);
      #2;
      rstn = 0;
      iDVAL = 0;
      q.delete();
      mMode = 0;
      #1;
      chkIdle("midreset");
      repeat (2) @(posedge clk);
      #1;
      chkIdle("midreset_hold");
      rstn = 1;

      frame(4, 4, 1, 1, 0, 0);
      chk("post_reset_count", outCnt, 9);
      chk("post_reset_mode", mode0, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/bayer_demosaic.md
# bayer_demosaic

Parametrised Bayer-to-RGB converter in the camera capture path, between the sensor capture/counter block and the RGB downstream (scaler/frame store). It generalises the fixed 12-bit, decimate-only converter. Data width, maximum line width and CFA phase are parameters. A run-time mode selects 2×2 decimation or full-resolution output. It owns its single-line RAM, reports line-overrun errors, and latches mode changes only at frame start.

## Interface
- DW, 12, pixel data width (R/G/B outputs same width)
- LINE_W, 1280, max pixels per line; line RAM depth
- XW, 11, width of iX_Cont
- YW, 11, width of iY_Cont
- BAYER, 2'b00, {row parity, col parity} of the R site; B at ~BAYER; G at the other two sites
- iCLK  in  1  clock
- iRST  in  1  reset, asynchronous, active-low
- iDATA  in  DW  raw pixel
- iDVAL  in  1  iDATA/iX_Cont/iY_Cont valid this cycle
- iX_Cont  in  XW  column of iDATA
- iY_Cont  in  YW  row of iDATA
- iMODE  in  1  0 = decimate (one RGB per 2×2 quad), 1 = full resolution
- oRed, oGreen, oBlue  out  DW each  RGB pixel
- oDVAL  out  1  RGB valid
- oMODE  out  1  mode currently in effect
- oOVF  out  1  sticky: a pixel arrived with iX_Cont ≥ LINE_W

## Operation
- Accepted pixel: iDVAL=1 and iX_Cont < LINE_W. Pixel with iX_Cont ≥ LINE_W: no RAM write, no output, oOVF←1. oOVF clears only on reset.
- Line RAM, addressed by iX_Cont. On an accepted pixel, RAM reads up = line[x] and writes line[x]←iDATA in the same cycle, read-before-write, so up is the previous row's pixel.
- Window registers advance only on accepted pixels: cur, cur_d (previous cur), up, up_d. The window covers rows y-1..y and cols x-1..x, so each parity site appears exactly once.
- Site parity of each window pixel is {row[0], col[0]}.
  - R = the window pixel whose parity == BAYER.
  - B = the window pixel whose parity == ~BAYER.
  - G = (Ga + Gb) computed at DW+1 bits; output bits [DW:1] (truncating average, no saturation needed).
- Output qualification (stage-1 x/y = coordinates of cur):
  - mode 0: emit only when x[0]=1 and y[0]=1. One pixel per quad; output frame is W/2 × H/2.
  - mode 1: emit when x ≥ 1 and y ≥ 1. Output frame is (W-1) × (H-1); row 0 and column 0 produce nothing.
- Mode latching: the active mode register loads iMODE only on an accepted pixel with iX_Cont=0 and iY_Cont=0. A change of iMODE at any other time is ignored until the next frame start. That frame-start pixel already uses the new mode. oMODE = active mode.
- Non-contiguous x (iDVAL gaps): the window holds; no flush, no timeout.
- Reset mid-frame: all pipeline state clears. RAM contents are don't-care because row 0 of the next frame never emits.

## Timing
- 2-stage pipeline, latency 2 cycles from accepted iDVAL to oDVAL.
  - Stage 1 (cycle N+1): registers cur, x, y, valid, and the RAM q.
  - Stage 2 (cycle N+2): registers RGB and oDVAL.
- Throughput: 1 pixel/clock; no backpressure.
- oDVAL is a single-cycle strobe per output. oRed/oGreen/oBlue hold their last value while oDVAL=0.
- Reset values: oRed=oGreen=oBlue=0, oDVAL=0, oMODE=0, oOVF=0. All window registers and the active mode are 0.
- Simultaneous frame start and mode change: the new mode applies to that pixel.
- Frame-start pixel in the overflow region (LINE_W=0 is illegal): LINE_W ≥ 2 is required, enforced by an elaboration check.

## Structure
- Package bayer_pkg holds:
  - mode constants MODE_DECIM=1'b0 and MODE_FULL=1'b1
  - function site_is(parity, BAYER) returning R/G/B
  - localparam for the green sum width (DW+1)
- Sub-module bayer_line_ram: single-port read-before-write RAM, depth LINE_W, width DW, address width $clog2(LINE_W), synchronous read, write enable = accepted. Inferable as block RAM.
- Top: qualification, window registers, mode latch, site mux, green adder, output registers.

## Test plan
- DW=12, BAYER=00, mode 0, 4×4 frame with pixel = 16·y + x:
  - at (y=1, x=1): window = 0, 1, 16, 17
  - R=0 (site 00), B=17 (site 11), G=(1+16)>>1=8
  - 4 oDVAL pulses total, each 2 cycles after x=1/3 of rows 1/3.
- Same frame, mode 1: 9 outputs. At (y=2, x=2): R=34 (site 00, pixel (2,2)), B=17, G=(18+33)>>1=25.
- BAYER=2'b11, same frame, mode 0, quad (1,1): R=17, B=0, G=8.
- Full-scale green: DW=12, both G sites = 4095 → oGreen=4095, no wrap.
- iMODE toggled 0→1 mid-frame: oMODE stays 0 and output count matches mode 0 until the next (0,0) pixel. From that pixel on, full-res output with oMODE=1.
- iX_Cont=LINE_W pixel injected → oOVF=1 permanently, no oDVAL for it. Then iRST pulsed low mid-line → all outputs 0 within the reset; the next frame decodes correctly.
